// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core.
// Word, opcode and PC-source encodings plus fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_t;

  localparam opcode_t HALT_OPCODE = 6'b111111;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Redirect decision and target address from the EX-stage control flow.
// Purely combinational; consumed by the fetch PC register.
module next_pc
  import cpu_types_pkg::*;
(
  input  logic [1:0]  i_pc_src,
  input  logic        i_br_taken,
  input  word_t       i_pc4,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_addr26,
  input  word_t       i_rs,
  output logic        o_redirect,
  output word_t       o_target
);

  word_t w_br_off;

  assign w_br_off = {{14{i_imm16[15]}}, i_imm16, 2'b00};

  always_comb begin
    o_redirect = 1'b0;
    o_target   = i_pc4;
    unique case (pc_src_t'(i_pc_src))
      PC_SEQ: begin
        o_redirect = 1'b0;
        o_target   = i_pc4;
      end
      PC_BR: begin
        o_redirect = i_br_taken;
        o_target   = i_pc4 + w_br_off;
      end
      PC_J: begin
        o_redirect = 1'b1;
        o_target   = {i_pc4[31:28], i_addr26, 2'b00};
      end
      PC_JR: begin
        o_redirect = 1'b1;
        o_target   = i_rs;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, icache request and IF/ID register.
// A HALT reaching decode freezes fetch until reset.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t   PC_INIT = 32'h0000_0000,
  parameter opcode_t HALT_OP = HALT_OPCODE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  word_t       iload,
  output logic        iREN,
  output word_t       iaddr,
  input  logic        stall,
  input  logic [1:0]  ex_pc_src,
  input  logic        ex_br_taken,
  input  word_t       ex_pc4,
  input  logic [15:0] ex_imm16,
  input  logic [25:0] ex_addr26,
  input  word_t       ex_rs,
  output logic        ifid_valid,
  output word_t       ifid_instr,
  output word_t       ifid_pc4,
  output opcode_t     opcode,
  output funct_t      funct,
  output logic        halted
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  word_t r_pc;
  word_t r_instr;
  word_t r_pc4;
  logic  r_valid;

  word_t w_pc_next;
  word_t w_instr_next;
  word_t w_pc4_next;
  logic  w_valid_next;

  word_t w_pc_plus4;
  word_t w_target;
  logic  w_redirect;
  logic  w_halt_hit;

  next_pc u_next_pc (
    .i_pc_src   (ex_pc_src),
    .i_br_taken (ex_br_taken),
    .i_pc4      (ex_pc4),
    .i_imm16    (ex_imm16),
    .i_addr26   (ex_addr26),
    .i_rs       (ex_rs),
    .o_redirect (w_redirect),
    .o_target   (w_target)
  );

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_halt_hit = r_valid & (r_instr[31:26] == HALT_OP) & ~stall;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_instr_next = r_instr;
    w_pc4_next   = r_pc4;
    if (r_state == FETCH) begin
      // Redirect outranks halt so a squashed HALT never freezes fetch
      if (w_redirect) begin
        w_pc_next    = w_target;
        w_valid_next = 1'b0;
        w_instr_next = '0;
        w_pc4_next   = '0;
      end else if (w_halt_hit) begin
        w_state_next = HALTED;
      end else if (stall) begin
        w_pc_next = r_pc;
      end else if (ihit) begin
        w_pc_next    = w_pc_plus4;
        w_valid_next = 1'b1;
        w_instr_next = iload;
        w_pc4_next   = w_pc_plus4;
      end else begin
        w_valid_next = 1'b0;
        w_instr_next = '0;
        w_pc4_next   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc4   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
      r_instr <= w_instr_next;
      r_pc4   <= w_pc4_next;
    end
  end

  assign iREN       = (r_state == FETCH);
  assign iaddr      = r_pc;
  assign ifid_valid = r_valid;
  assign ifid_instr = r_instr;
  assign ifid_pc4   = r_pc4;
  assign opcode     = r_instr[31:26];
  assign funct      = r_instr[5:0];
  assign halted     = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal checks plus random
// traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] iload = '0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall = 1'b0;
  logic [1:0]  ex_pc_src = 2'b00;
  logic        ex_br_taken = 1'b0;
  logic [31:0] ex_pc4 = '0;
  logic [15:0] ex_imm16 = '0;
  logic [25:0] ex_addr26 = '0;
  logic [31:0] ex_rs = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        halted;

  int n_pass = 0;
  int n_total = 0;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload),
    .iREN(iREN), .iaddr(iaddr), .stall(stall),
    .ex_pc_src(ex_pc_src), .ex_br_taken(ex_br_taken),
    .ex_pc4(ex_pc4), .ex_imm16(ex_imm16),
    .ex_addr26(ex_addr26), .ex_rs(ex_rs),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .opcode(opcode), .funct(funct),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Behavioural model: architectural PC and IF/ID contents
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted, m_live = 1'b0;

  always @(posedge CLK) begin
    logic        redir;
    logic [31:0] tgt;
    if (RST) begin
      m_pc = 32'h0; m_valid = 0; m_instr = 0;
      m_pc4 = 0; m_halted = 0; m_live = 1'b1;
    end else if (m_live && !m_halted) begin
      redir = 0;
      tgt = 0;
      if (ex_pc_src == 2'd1 && ex_br_taken) begin
        redir = 1;
        tgt = ex_pc4 + 32'($signed(ex_imm16)) * 4;
      end else if (ex_pc_src == 2'd2) begin
        redir = 1;
        tgt = (ex_pc4 & 32'hF000_0000) + {6'd0, ex_addr26} * 4;
      end else if (ex_pc_src == 2'd3) begin
        redir = 1;
        tgt = ex_rs;
      end
      if (redir) begin
        m_pc = tgt; m_valid = 0; m_instr = 0; m_pc4 = 0;
      end else if (m_valid && (m_instr >> 26) == 63 && !stall) begin
        m_halted = 1;
      end else if (stall) begin
        m_halted = 0;
      end else if (ihit) begin
        m_pc = m_pc + 4;
        m_valid = 1; m_instr = iload; m_pc4 = m_pc;
      end else begin
        m_valid = 0; m_instr = 0; m_pc4 = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      check("iaddr", iaddr, m_pc);
      check("iREN", {31'd0, iREN}, {31'd0, !m_halted});
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check("instr", ifid_instr, m_instr);
      check("pc4", ifid_pc4, m_pc4);
      check("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
      check("funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic ex_idle();
    ex_pc_src = 2'b00; ex_br_taken = 0; ex_pc4 = 0;
    ex_imm16 = 0; ex_addr26 = 0; ex_rs = 0;
  endtask

  initial begin
    @(negedge CLK);
    tick();
    RST = 0;
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd1);

    ihit = 1; iload = 32'h2001_0005; tick();
    check("t1_iaddr", iaddr, 32'h4);
    check("t1_instr", ifid_instr, 32'h2001_0005);
    check("t1_pc4", ifid_pc4, 32'h4);
    check("t1_op", {26'd0, opcode}, 32'h08);
    iload = 32'h2002_0007; tick();
    check("t1_iaddr2", iaddr, 32'h8);
    check("t1_instr2", ifid_instr, 32'h2002_0007);
    check("t1_pc4_2", ifid_pc4, 32'h8);

    iload = 0; tick(); tick();
    ihit = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_iaddr", iaddr, 32'h10);
      check("t2_valid", {31'd0, ifid_valid}, 32'd0);
      check("t2_instr", ifid_instr, 32'h0);
    end
    ihit = 1; iload = 32'h0000_1234; tick();
    check("t2_resume", iaddr, 32'h14);

    stall = 1; iload = 32'h0000_AAAA;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_iaddr", iaddr, 32'h14);
      check("t3_instr", ifid_instr, 32'h0000_1234);
    end
    stall = 0; iload = 32'h0000_5555; tick();
    check("t3_instr2", ifid_instr, 32'h0000_5555);
    check("t3_pc4", ifid_pc4, 32'h18);

    ex_pc_src = 2'b01; ex_br_taken = 1;
    ex_pc4 = 32'h20; ex_imm16 = 16'hFFFC; tick();
    check("t4_br", iaddr, 32'h10);
    check("t4_bubble", {31'd0, ifid_valid}, 32'd0);
    ex_br_taken = 0; tick();
    check("t4_nt", iaddr, 32'h14);
    ex_pc_src = 2'b10; ex_pc4 = 32'h8000_0004;
    ex_addr26 = 26'h40; tick();
    check("t4_j", iaddr, 32'h8000_0100);
    ex_pc_src = 2'b11; ex_rs = 32'h44; tick();
    check("t4_jr", iaddr, 32'h44);
    ex_idle();

    iload = 32'hFFFF_FFFF; tick();
    check("t5_op", {26'd0, opcode}, 32'h3F);
    iload = 32'h1111_1111; tick();
    check("t5_halt", {31'd0, halted}, 32'd1);
    check("t5_iren", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0];
      tick();
      check("t5_frozen", iaddr, 32'h48);
    end
    RST = 1; tick(); RST = 0;
    check("t5_rst_pc", iaddr, 32'h0);
    check("t5_rst_h", {31'd0, halted}, 32'd0);

    ihit = 1; iload = 32'hFC00_0000; tick();
    ex_pc_src = 2'b01; ex_br_taken = 1;
    ex_pc4 = 32'h20; ex_imm16 = 16'h0001; tick();
    check("t6_nohalt", {31'd0, halted}, 32'd0);
    check("t6_target", iaddr, 32'h24);
    check("t6_valid", {31'd0, ifid_valid}, 32'd0);
    ex_idle(); iload = 32'h2003_0001; tick();
    stall = 1; tick();
    RST = 1; tick(); RST = 0; stall = 0;
    check("t6_rst_pc", iaddr, 32'h0);
    check("t6_rst_instr", ifid_instr, 32'h0);
    check("t6_rst_pc4", ifid_pc4, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 149) == 0);
      ihit = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 5) == 0);
      iload = $urandom;
      if ($urandom_range(0, 24) == 0) iload[31:26] = 6'h3F;
      ex_idle();
      if ($urandom_range(0, 4) == 0) begin
        ex_pc_src = 2'($urandom_range(1, 3));
        ex_br_taken = $urandom_range(0, 1) == 1;
        ex_pc4 = $urandom;
        ex_imm16 = 16'($urandom);
        ex_addr26 = 26'($urandom);
        ex_rs = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
